// File: rtl/voice_mix_scheduler.sv
// Per-frame voice mixer: polls each enabled voice over req/ack, sums the samples,
// applies master gain with saturation and presents the result one frame later.
module voice_mix_scheduler #(
  parameter int NUM_VOICES   = 8,
  parameter int FRAME_CYCLES = 1024,
  parameter int ACK_TIMEOUT  = 64
) (
  input  logic                          clk48m,
  input  logic                          rst,
  input  logic [NUM_VOICES-1:0]         voice_enable,
  input  logic [7:0]                    master_gain,
  input  logic                          voice_ack,
  input  logic [23:0]                   voice_sample,
  input  logic                          err_clr,
  output logic                          voice_req,
  output logic [$clog2(NUM_VOICES)-1:0] voice_sel,
  output logic [23:0]                   signal,
  output logic                          frame_tick,
  output logic                          busy,
  output logic                          timeout_err,
  output logic                          overrun
);
  localparam int SEL_W  = $clog2(NUM_VOICES);
  localparam int ACC_W  = 24 + SEL_W;
  localparam int PROD_W = ACC_W + 9;
  localparam int FC_W   = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
  localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SEL, WAIT, NEXT, SCALE} state_t;

  state_t                   state;
  logic [FC_W-1:0]          frame_cnt;
  logic [NUM_VOICES-1:0]    snap;
  logic [SEL_W-1:0]         idx;
  logic [TO_W-1:0]          wait_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic [23:0]              pending;
  logic signed [PROD_W-1:0] prod, res;
  logic [PROD_W-24:0]       res_hi;
  logic [23:0]              sat;
  logic signed [ACC_W-1:0]  sample_ext;

  always_ff @(posedge clk48m or posedge rst) begin
    if (rst)
      frame_cnt <= FC_W'(FRAME_CYCLES - 1);
    else if (frame_cnt == FC_W'(FRAME_CYCLES - 1))
      frame_cnt <= '0;
    else
      frame_cnt <= frame_cnt + FC_W'(1);
  end

  assign frame_tick = (frame_cnt == '0);

  // Gain is unsigned: zero-extend before the signed multiply; >>> 7 floors toward -inf.
  assign sample_ext = {{SEL_W{voice_sample[23]}}, voice_sample};
  assign prod   = $signed(acc) * $signed({1'b0, master_gain});
  assign res    = prod >>> 7;
  assign res_hi = res[PROD_W-1:23];
  assign sat    = ((&res_hi) || !(|res_hi)) ? res[23:0]
                : (res[PROD_W-1] ? 24'h800000 : 24'h7FFFFF);

  always_ff @(posedge clk48m or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      snap        <= '0;
      idx         <= '0;
      wait_cnt    <= '0;
      acc         <= '0;
      pending     <= '0;
      signal      <= '0;
      voice_req   <= 1'b0;
      voice_sel   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // Clear first so a set in the same cycle takes precedence.
      if (err_clr) begin
        timeout_err <= 1'b0;
        overrun     <= 1'b0;
      end
      if (frame_tick) begin
        signal    <= pending;
        if (busy) overrun <= 1'b1;
        snap      <= voice_enable;
        acc       <= '0;
        idx       <= '0;
        voice_req <= 1'b0;
        busy      <= 1'b1;
        state     <= SEL;
      end else begin
        case (state)
          IDLE: ;
          SEL: begin
            if (!snap[idx]) begin
              state <= NEXT;
            end else begin
              voice_sel <= idx;
              voice_req <= 1'b1;
              wait_cnt  <= '0;
              state     <= WAIT;
            end
          end
          WAIT: begin
            if (voice_ack) begin
              acc       <= acc + sample_ext;
              voice_req <= 1'b0;
              state     <= NEXT;
            end else if (wait_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
              voice_req   <= 1'b0;
              timeout_err <= 1'b1;
              state       <= NEXT;
            end else begin
              wait_cnt <= wait_cnt + TO_W'(1);
            end
          end
          NEXT: begin
            if (idx == SEL_W'(NUM_VOICES - 1)) begin
              state <= SCALE;
            end else begin
              idx   <= idx + SEL_W'(1);
              state <= SEL;
            end
          end
          SCALE: begin
            pending <= sat;
            busy    <= 1'b0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Directed bench: main instance at default timing, second instance with a short
// frame and long ack timeout to force overrun.
module tb_voice_mix_scheduler;
  logic        clk48m = 1'b0;
  logic        rst;
  logic [7:0]  voice_enable;
  logic [7:0]  master_gain;
  logic        voice_ack;
  logic [23:0] voice_sample;
  logic        err_clr;
  logic        voice_req;
  logic [2:0]  voice_sel;
  logic [23:0] signal;
  logic        frame_tick, busy, timeout_err, overrun;

  logic        b_req;
  logic [2:0]  b_sel;
  logic [23:0] b_signal;
  logic        b_tick, b_busy, b_terr, b_overrun;

  logic [23:0] samples [8];
  logic [7:0]  noack;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk48m = ~clk48m;

  voice_mix_scheduler dut (
    .clk48m(clk48m), .rst(rst), .voice_enable(voice_enable), .master_gain(master_gain),
    .voice_ack(voice_ack), .voice_sample(voice_sample), .err_clr(err_clr),
    .voice_req(voice_req), .voice_sel(voice_sel), .signal(signal), .frame_tick(frame_tick),
    .busy(busy), .timeout_err(timeout_err), .overrun(overrun)
  );

  voice_mix_scheduler #(.NUM_VOICES(8), .FRAME_CYCLES(64), .ACK_TIMEOUT(100)) dut_b (
    .clk48m(clk48m), .rst(rst), .voice_enable(8'h01), .master_gain(8'd128),
    .voice_ack(1'b0), .voice_sample(24'h0), .err_clr(1'b0),
    .voice_req(b_req), .voice_sel(b_sel), .signal(b_signal), .frame_tick(b_tick),
    .busy(b_busy), .timeout_err(b_terr), .overrun(b_overrun)
  );

  // Voice model: answer a pending request shortly after the edge that raised it.
  always @(posedge clk48m) begin
    #1;
    if (voice_req && !voice_ack && !noack[voice_sel]) begin
      voice_ack    = 1'b1;
      voice_sample = samples[voice_sel];
    end else begin
      voice_ack = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Returns at the negedge just after the next frame_tick edge.
  task automatic next_tick();
    int n = 0;
    while (!frame_tick && n < 1100) begin
      @(negedge clk48m);
      n++;
    end
    chk("tick_seen", {31'b0, frame_tick}, 32'd1);
    @(negedge clk48m);
  endtask

  task automatic mix_frame();
    next_tick();
    next_tick();
  endtask

  initial begin
    int n;
    int req3;
    rst = 1'b1; err_clr = 1'b0; voice_ack = 1'b0; voice_sample = '0;
    noack = 8'h00; master_gain = 8'd128; voice_enable = 8'h01;
    for (int i = 0; i < 8; i++) samples[i] = 24'h0;
    samples[0] = 24'h000100;
    repeat (2) @(negedge clk48m);
    chk("rst_signal", {8'b0, signal}, 32'h0);
    chk("rst_req", {31'b0, voice_req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_tick", {31'b0, frame_tick}, 32'd0);
    chk("rst_flags", {30'b0, timeout_err, overrun}, 32'd0);
    rst = 1'b0;

    // Overrun on the short-frame instance
    n = 0;
    while (!b_tick && n < 10) begin @(negedge clk48m); n++; end
    chk("b_first_tick", {31'b0, b_tick}, 32'd1);
    @(negedge clk48m);
    n = 0;
    while (!b_tick && n < 100) begin @(negedge clk48m); n++; end
    chk("b_second_tick", {31'b0, b_tick}, 32'd1);
    chk("b_req_before", {31'b0, b_req}, 32'd1);
    chk("b_busy_before", {31'b0, b_busy}, 32'd1);
    @(negedge clk48m);
    chk("b_overrun", {31'b0, b_overrun}, 32'd1);
    chk("b_req_dropped", {31'b0, b_req}, 32'd0);
    chk("b_signal_unch", {8'b0, b_signal}, 32'h0);
    chk("b_terr", {31'b0, b_terr}, 32'd0);
    @(negedge clk48m);
    chk("b_restart_req", {31'b0, b_req}, 32'd1);
    chk("b_restart_sel", {29'b0, b_sel}, 32'd0);

    // Single voice at unity gain
    mix_frame();
    chk("t1_signal", {8'b0, signal}, 32'h000100);
    chk("t1_flags", {30'b0, timeout_err, overrun}, 32'd0);
    samples[0] = 24'h000200;
    repeat (500) @(negedge clk48m);
    chk("t1_hold", {8'b0, signal}, 32'h000100);
    next_tick();
    chk("t1_latency", {8'b0, signal}, 32'h000200);

    // Saturation at both rails
    voice_enable = 8'hFF;
    for (int i = 0; i < 8; i++) samples[i] = 24'h7FFFFF;
    mix_frame();
    chk("t2_pos_sat", {8'b0, signal}, 32'h7FFFFF);
    for (int i = 0; i < 8; i++) samples[i] = 24'h800000;
    mix_frame();
    chk("t2_neg_sat", {8'b0, signal}, 32'h800000);

    // Half gain, including floor of a negative odd result
    voice_enable = 8'h03; master_gain = 8'd64;
    samples[0] = 24'h001000; samples[1] = 24'h001000;
    mix_frame();
    chk("t3_half", {8'b0, signal}, 32'h001000);
    samples[0] = 24'hFFFFFF; samples[1] = 24'hFFFFFE;
    mix_frame();
    chk("t3_floor", {8'b0, signal}, 32'hFFFFFE);

    // Voice 3 never acks
    voice_enable = 8'hFF; master_gain = 8'd128; noack = 8'h08;
    for (int i = 0; i < 8; i++) samples[i] = 24'h000010;
    next_tick();
    req3 = 0; n = 0;
    while (!frame_tick && n < 1100) begin
      if (voice_req && voice_sel == 3'd3) req3++;
      @(negedge clk48m);
      n++;
    end
    @(negedge clk48m);
    chk("t4_req_cycles", req3, 32'd64);
    chk("t4_signal", {8'b0, signal}, 32'h000070);
    chk("t4_terr", {31'b0, timeout_err}, 32'd1);
    chk("t4_overrun", {31'b0, overrun}, 32'd0);
    noack = 8'h00;
    err_clr = 1'b1;
    @(negedge clk48m);
    err_clr = 1'b0;
    chk("t4_clr", {31'b0, timeout_err}, 32'd0);

    // Asynchronous reset while waiting on a voice
    voice_enable = 8'h03; noack = 8'h03;
    next_tick();
    repeat (69) @(negedge clk48m);
    chk("t6_req_pre", {31'b0, voice_req}, 32'd1);
    chk("t6_terr_pre", {31'b0, timeout_err}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_req", {31'b0, voice_req}, 32'd0);
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_signal", {8'b0, signal}, 32'h0);
    chk("t6_flags", {30'b0, timeout_err, overrun}, 32'd0);
    @(negedge clk48m);
    rst = 1'b0;
    @(negedge clk48m);
    chk("t6_first_tick", {31'b0, frame_tick}, 32'd1);
    @(negedge clk48m);
    chk("t6_busy_again", {31'b0, busy}, 32'd1);
    @(negedge clk48m);
    chk("t6_req_again", {31'b0, voice_req}, 32'd1);
    chk("t6_sel_again", {29'b0, voice_sel}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/voice_mix_scheduler.md
Name: voice_mix_scheduler

Overview:
Per-frame scheduler that supplies the I2S transmitter with one mixed sample per audio frame. On every frame boundary it polls up to NUM_VOICES voice generators in turn over a req/ack handshake and accumulates their signed samples. It then applies master gain, saturates to 24 bits and presents the result on signal. Sits between the voice generators and the I2S transmitter; frame period matches the transmitter LR period of 1024 clk48m cycles.

Parameters:
NUM_VOICES, 8, number of voice generators polled per frame (2..16).
FRAME_CYCLES, 1024, clk48m cycles per audio frame.
ACK_TIMEOUT, 64, maximum cycles to wait for voice_ack before skipping a voice.

Ports:
clk48m  input  1  system clock, 48 MHz.
rst  input  1  reset, asynchronous, active-high.
voice_enable  input  NUM_VOICES  per-voice enable; snapshotted at frame start.
master_gain  input  8  unsigned gain, 128 = unity; sampled in SCALE.
voice_ack  input  1  voice_sample valid; only honoured while voice_req=1.
voice_sample  input  24  signed two's-complement sample from the selected voice.
err_clr  input  1  synchronous clear of the sticky error flags.
voice_req  output  1  request to the voice selected by voice_sel.
voice_sel  output  clog2(NUM_VOICES)  index of the voice being polled.
signal  output  24  signed mixed sample to the I2S transmitter.
frame_tick  output  1  one-cycle pulse at each frame boundary.
busy  output  1  high while a mix sequence is in progress.
timeout_err  output  1  sticky; a voice failed to ack within ACK_TIMEOUT.
overrun  output  1  sticky; a sequence was still running at a frame boundary.

Behaviour:
- Reset: all outputs 0, accumulator 0, pending result 0, state IDLE, frame counter FRAME_CYCLES-1.
- Frame counter: wraps to 0 after FRAME_CYCLES-1. frame_tick=1 in the cycle the counter equals 0.
  - First tick follows the first clk48m edge after reset release.
  - Later ticks occur every FRAME_CYCLES cycles.
- At tick:
  - signal <= pending result (last completed mix).
  - Then the sequence starts: snapshot voice_enable, acc=0, idx=0, state SEL.
- States:
  - IDLE: waits for tick.
  - SEL: if snapshot[idx]=0, go to NEXT. Otherwise voice_sel<=idx, voice_req<=1, wait-counter=0, go to WAIT.
  - WAIT: voice_sel and voice_req stay stable.
    - On voice_ack=1: acc += sign-extended voice_sample; voice_req<=0 next cycle; go to NEXT.
    - If the wait-counter reaches ACK_TIMEOUT without ack: voice_req<=0, timeout_err<=1, contribution 0, go to NEXT.
  - NEXT: if idx=NUM_VOICES-1, go to SCALE; else idx++ and go to SEL.
  - SCALE: prod = acc * master_gain (signed × unsigned); res = prod >>> 7 (arithmetic, floor). Saturate to 0x7FFFFF / 0x800000. pending <= res; go to IDLE.
- Widths:
  - acc: 24+clog2(NUM_VOICES) bits, no internal overflow.
  - prod: acc width + 9 bits.
- busy=1 in every state except IDLE.
- voice_ack while voice_req=0 is ignored. Ack in the same cycle as timeout expiry counts as ack (no error).
- Latency: samples mixed after tick k appear on signal at tick k+1, constant one frame.
- Overrun: a tick while busy=1:
  - sets overrun=1 and aborts the sequence (voice_req<=0 the same edge);
  - signal takes the previous pending value;
  - the new sequence restarts from idx 0.
- err_clr=1 clears timeout_err and overrun. A set event in the same cycle wins.
- signal changes only on tick cycles.
- Reset mid-sequence returns everything to reset values immediately (asynchronous).

Test Plan:
1. Only voice 0 enabled, sample 0x000100, gain 128, ack 1 cycle after req -> signal=0x000100 after the second tick; timeout_err=0, overrun=0.
2. All 8 voices 0x7FFFFF, gain 128 -> signal=0x7FFFFF. All 8 voices 0x800000 -> signal=0x800000 (saturation both rails).
3. Gain 64 with two voices 0x001000 -> signal=0x001000. Voices −1 and −2 (sum −3) with gain 64 -> signal=0xFFFFFE (floor).
4. Voice 3 never acks, others 0x000010 -> voice_req drops after 64 cycles, timeout_err=1, signal=0x000070. err_clr pulse -> timeout_err=0.
5. FRAME_CYCLES=64, ACK_TIMEOUT=100, voice 0 never acks -> overrun=1 at the next tick, voice_req low that cycle, signal unchanged, sequence restarts with voice_sel=0.
6. Assert rst while voice_req=1 in WAIT -> voice_req, busy, signal and the flags go 0 without a clock edge. After release, first tick on the first edge and the sequence restarts.
